// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage for a VGA timing chain: turns position/active/sync into
// RGB test patterns, delays the syncs to match the colour pipeline, and applies
// pattern-mode requests only at frame boundaries.
module vga_pattern_gen #(
  parameter int H_VIS     = 640,
  parameter int COLOR_W   = 4,
  parameter int BAR_SPEED = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_en,
  input  logic [11:0]        i_h_pos,
  input  logic [11:0]        i_v_pos,
  input  logic               i_h_active,
  input  logic               i_v_active,
  input  logic               i_h_sync_in,
  input  logic               i_v_sync_in,
  input  logic               i_frame_start,
  input  logic [1:0]         i_mode_req,
  input  logic               i_mode_req_valid,
  output logic               o_mode_ack,
  output logic [1:0]         o_mode_cur,
  output logic [COLOR_W-1:0] o_r,
  output logic [COLOR_W-1:0] o_g,
  output logic [COLOR_W-1:0] o_b,
  output logic               o_h_sync_out,
  output logic               o_v_sync_out
);

  localparam int               BAR_W  = H_VIS / 8;
  localparam logic [COLOR_W-1:0] C_F  = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_0  = '0;

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_ack_next;
  logic        w_capture;
  logic        w_apply;
  logic [1:0]  r_pend;
  logic [1:0]  r_mode_cur;
  logic        r_ack;
  logic [10:0] r_offset;
  logic [11:0] w_offset_sum;

  logic [11:0] r_s1_hpos;
  logic        r_s1_v4;
  logic        r_s1_active;
  logic        r_s1_hsync;
  logic        r_s1_vsync;
  logic [1:0]  r_s1_mode;
  logic [10:0] r_s1_offset;

  logic [2:0]         w_bar_idx;
  logic [11:0]        w_bar_end;
  logic [COLOR_W-1:0] w_r, w_g, w_b;
  logic [COLOR_W-1:0] r_r, r_g, r_b;
  logic               r_hsync_out, r_vsync_out;

  // Only bit 4 of the vertical position matters (checker cell row).
  logic w_unused_vpos;
  assign w_unused_vpos = ^{i_v_pos[11:5], i_v_pos[3:0]};

  // Request FSM next-state: capture in IDLE, apply in PENDING at frame start.
  always_comb begin
    w_state_next = r_state;
    w_ack_next   = 1'b0;
    w_capture    = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_mode_req_valid) begin
          w_state_next = ST_PENDING;
          w_ack_next   = 1'b1;
          w_capture    = 1'b1;
        end
      end
      ST_PENDING: begin
        if (i_frame_start && i_pix_en) begin
          w_state_next = ST_IDLE;
          w_apply      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request FSM state, ack pulse, pending and current mode registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_pend     <= 2'd0;
      r_mode_cur <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_next;
      if (w_capture) r_pend <= i_mode_req;
      if (w_apply)   r_mode_cur <= r_pend;
    end
  end

  assign w_offset_sum = {1'b0, r_offset} + 12'(BAR_SPEED);

  // Moving-bar offset: advances once per frame while mode 3 is shown,
  // restarts from 0 whenever mode 3 is newly applied.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_offset <= '0;
    end else if (w_apply && r_pend == 2'd3) begin
      r_offset <= '0;
    end else if (i_frame_start && i_pix_en && r_mode_cur == 2'd3) begin
      if (w_offset_sum >= 12'(H_VIS)) r_offset <= '0;
      else                            r_offset <= w_offset_sum[10:0];
    end
  end

  // Stage 1: register pixel inputs together with the mode/offset they use,
  // so pixels in flight across a frame boundary keep the old settings.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_hpos   <= '0;
      r_s1_v4     <= 1'b0;
      r_s1_active <= 1'b0;
      r_s1_hsync  <= 1'b1;
      r_s1_vsync  <= 1'b1;
      r_s1_mode   <= 2'd0;
      r_s1_offset <= '0;
    end else if (i_pix_en) begin
      r_s1_hpos   <= i_h_pos;
      r_s1_v4     <= i_v_pos[4];
      r_s1_active <= i_h_active & i_v_active;
      r_s1_hsync  <= i_h_sync_in;
      r_s1_vsync  <= i_v_sync_in;
      r_s1_mode   <= r_mode_cur;
      r_s1_offset <= r_offset;
    end
  end

  // Bar index by threshold compare against multiples of the bar width.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_s1_hpos >= 12'(k * BAR_W)) w_bar_idx = 3'(k);
    end
  end

  assign w_bar_end = {1'b0, r_s1_offset} + 12'd16;

  // Colour selection from stage-1 values.
  always_comb begin
    w_r = C_0;
    w_g = C_0;
    w_b = C_0;
    if (r_s1_active) begin
      case (r_s1_mode)
        2'd1: begin
          case (w_bar_idx)
            3'd0: begin w_r = C_F; w_g = C_F; w_b = C_F; end
            3'd1: begin w_r = C_F; w_g = C_F; w_b = C_0; end
            3'd2: begin w_r = C_0; w_g = C_F; w_b = C_F; end
            3'd3: begin w_r = C_0; w_g = C_F; w_b = C_0; end
            3'd4: begin w_r = C_F; w_g = C_0; w_b = C_F; end
            3'd5: begin w_r = C_F; w_g = C_0; w_b = C_0; end
            3'd6: begin w_r = C_0; w_g = C_0; w_b = C_F; end
            default: begin w_r = C_0; w_g = C_0; w_b = C_0; end
          endcase
        end
        2'd2: begin
          if ((r_s1_hpos[4] ^ r_s1_v4) == 1'b0) begin
            w_r = C_F; w_g = C_F; w_b = C_F;
          end
        end
        2'd3: begin
          if (r_s1_hpos >= {1'b0, r_s1_offset} && r_s1_hpos < w_bar_end) begin
            w_r = C_F; w_g = C_F; w_b = C_F;
          end else begin
            w_b = C_F;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 2: registered colour and delayed syncs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_hsync_out <= 1'b1;
      r_vsync_out <= 1'b1;
    end else if (i_pix_en) begin
      r_r         <= w_r;
      r_g         <= w_g;
      r_b         <= w_b;
      r_hsync_out <= r_s1_hsync;
      r_vsync_out <= r_s1_vsync;
    end
  end

  assign o_mode_ack   = r_ack;
  assign o_mode_cur   = r_mode_cur;
  assign o_r          = r_r;
  assign o_g          = r_g;
  assign o_b          = r_b;
  assign o_h_sync_out = r_hsync_out;
  assign o_v_sync_out = r_vsync_out;

endmodule
